// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32 pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_BUSY = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // x0 is hardwired to zero, so it never matches as a producer
  function automatic logic rd_hit(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Execute-stage operand source select for one source register; MEM result wins over WB.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rd_m,
  input  logic       i_reg_write_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_reg_write_w,
  output logic [1:0] o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_reg_write_m && rd_hit(i_rd_m, i_rs)) begin
      o_sel = FWD_MEM;
    end else if (i_reg_write_w && rd_hit(i_rd_w, i_rs)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control for the five-stage RV32 core.
// Build option HAZARD_FWD_EN: Execute-stage forwarding; without it, RAW hazards stall Decode.
//
// state    | meaning
// RUN      | normal flow; MDU op or blocked data access may start a wait
// MDU_BUSY | MDU op held in Execute, r_mdu_cnt counts remaining stall cycles
// MEM_WAIT | data memory not ready; r_resume marks an interrupted MDU op
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             MduE,
  input  logic             MemReqM,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCnt
);

  localparam int MDU_W = $clog2(MDU_CYCLES);
  localparam logic [MDU_W-1:0] MDU_LOAD = MDU_W'(MDU_CYCLES - 2);
  localparam logic [MDU_W-1:0] MDU_ONE  = MDU_W'(1);

  hz_state_e        r_state, w_state_nxt;
  logic [MDU_W-1:0] r_mdu_cnt, w_mdu_cnt_nxt;
  logic             r_resume, w_resume_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_mem_req_wait, w_mem_stall, w_mdu_active, w_mdu_stall;
  logic       w_load_use, w_data_stall;
  logic [1:0] w_fwd_a, w_fwd_b;

  assign w_mem_req_wait = MemReqM && !dmem_ready;
  assign w_mem_stall    = w_mem_req_wait || ((r_state == MEM_WAIT) && !dmem_ready);
  assign w_mdu_active   = (r_state == MDU_BUSY) || ((r_state == MEM_WAIT) && r_resume);
  // count reaching zero releases Execute in that same cycle, so the op leaves on its edge
  assign w_mdu_stall    = ((r_state == RUN) && MduE) || (w_mdu_active && (r_mdu_cnt != '0));
  assign w_load_use     = LoadE && (rd_hit(RdE, Rs1D) || rd_hit(RdE, Rs2D));

  fwd_sel u_fwd_a (
    .i_rs          (Rs1E),
    .i_rd_m        (RdM),
    .i_reg_write_m (RegWriteM),
    .i_rd_w        (RdW),
    .i_reg_write_w (RegWriteW),
    .o_sel         (w_fwd_a)
  );

  fwd_sel u_fwd_b (
    .i_rs          (Rs2E),
    .i_rd_m        (RdM),
    .i_reg_write_m (RegWriteM),
    .i_rd_w        (RdW),
    .i_reg_write_w (RegWriteW),
    .o_sel         (w_fwd_b)
  );

`ifdef HAZARD_FWD_EN
  logic w_unused_fwd;
  assign w_unused_fwd = RegWriteE;
  assign w_data_stall = w_load_use;
  assign ForwardAE    = reset ? w_fwd_a : FWD_RF;
  assign ForwardBE    = reset ? w_fwd_b : FWD_RF;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{w_fwd_a, w_fwd_b};
  // W-stage producers are covered by register-file write-through
  assign w_data_stall = w_load_use
                     || (RegWriteE && (rd_hit(RdE, Rs1D) || rd_hit(RdE, Rs2D)))
                     || (RegWriteM && (rd_hit(RdM, Rs1D) || rd_hit(RdM, Rs2D)));
  assign ForwardAE    = FWD_RF;
  assign ForwardBE    = FWD_RF;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_mdu_cnt_nxt = r_mdu_cnt;
    w_resume_nxt  = r_resume;
    unique case (r_state)
      RUN: begin
        if (w_mem_req_wait) begin
          w_state_nxt  = MEM_WAIT;
          w_resume_nxt = 1'b0;
        end else if (MduE) begin
          w_state_nxt   = MDU_BUSY;
          w_mdu_cnt_nxt = MDU_LOAD;
        end
      end
      MDU_BUSY: begin
        if (w_mem_req_wait) begin
          w_state_nxt  = MEM_WAIT;
          w_resume_nxt = 1'b1;
        end else if (r_mdu_cnt == '0) begin
          w_state_nxt = RUN;
        end else begin
          w_mdu_cnt_nxt = r_mdu_cnt - MDU_ONE;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          w_resume_nxt = 1'b0;
          if (r_resume && (r_mdu_cnt != '0)) begin
            w_state_nxt   = MDU_BUSY;
            w_mdu_cnt_nxt = r_mdu_cnt - MDU_ONE;
          end else begin
            w_state_nxt = RUN;
          end
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;
    if (w_mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (w_mdu_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else begin
      if (w_data_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
    end
    if (!imem_ready) begin
      StallF = 1'b1;
      if (!StallD) FlushD = 1'b1;
    end
    if (!reset) begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushM = 1'b0;
      FlushW = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_mdu_cnt   <= '0;
      r_resume    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mdu_cnt <= w_mdu_cnt_nxt;
      r_resume  <= w_resume_nxt;
      if (StallF && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign StallCnt = r_stall_cnt;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage RV32 core. It watches register addresses and control bits from the Decode, Execute, Memory and Writeback stages, plus instruction/data memory ready signals and multi-cycle MDU operations. It produces the per-stage stall/flush enables consumed by the F/D/E/M pipeline registers, and the Execute-stage forwarding selects. A registered FSM sequences the multi-cycle MDU and data-memory wait periods.

## Interface
- MDU_CYCLES, 4, total cycles an MDU op occupies Execute (≥2)
- CNT_W, 32, width of stall-cycle counter
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  5 each  source regs in Decode
- Rs1E, Rs2E, RdE  in  5 each  source/dest regs in Execute
- RdM, RdW  in  5 each  dest regs in Memory/Writeback
- RegWriteE, RegWriteM, RegWriteW  in  1 each  stage writes rd
- LoadE  in  1  load in Execute (ResultSrcE selects memory)
- PCSrcE  in  1  taken branch/jump resolved in Execute
- MduE  in  1  MUL/DIV op in Execute
- MemReqM  in  1  load/store in Memory
- imem_ready, dmem_ready  in  1 each  memory ready
- StallF, StallD, StallE, StallM  out  1 each  hold stage register
- FlushD, FlushE, FlushM, FlushW  out  1 each  clear stage register to bubble
- ForwardAE, ForwardBE  out  2 each  operand source select
- StallCnt  out  CNT_W  cycles with StallF=1, saturating

## Operation
- FSM states: RUN, MDU_BUSY, MEM_WAIT. Reset → RUN, counter 0, StallCnt 0.
- RUN→MEM_WAIT: MemReqM & ~dmem_ready. MEM_WAIT→RUN: dmem_ready.
- RUN→MDU_BUSY: MduE & not entering MEM_WAIT; load mdu_cnt = MDU_CYCLES-2. MDU_BUSY decrements; mdu_cnt==0 → RUN. MemReqM & ~dmem_ready in MDU_BUSY → MEM_WAIT, mdu_cnt frozen; MEM_WAIT resumes MDU_BUSY if mdu_cnt≠0 was pending (resume flag bit).
- Priority (highest first):
  - MEM stall (state MEM_WAIT or RUN with MemReqM & ~dmem_ready): StallF/D/E/M=1, FlushW=1; all other flushes 0.
  - MDU stall (MDU_BUSY, or RUN with MduE): StallF/D/E=1, FlushM=1.
  - Load-use: LoadE & RdE≠0 & (RdE==Rs1D | RdE==Rs2D) → StallF, StallD, FlushE.
  - Branch: PCSrcE → FlushD, FlushE (combines with load-use).
  - Fetch wait: ~imem_ready → StallF=1; FlushD=1 unless StallD=1.
- Forwarding (per operand, Rs1E→A, Rs2E→B): 2'b10 if RegWriteM & RdM≠0 & RdM==RsE; else 2'b01 if RegWriteW & RdW≠0 & RdW==RsE; else 2'b00. MEM wins over WB.
- x0 never creates a hazard or forward.
- StallCnt increments every cycle StallF=1; holds at all-ones.

## Timing
- Stall/flush/forward outputs combinational from current inputs and registered state; same-cycle effect.
- State, mdu_cnt and StallCnt update on rising clk.
- MDU op: StallE high exactly MDU_CYCLES-1 cycles starting the cycle MduE first seen; op leaves E on the following edge.
- Reset asserted (low) at any time: state→RUN immediately, all outputs 0, StallCnt 0; in-flight MDU count discarded.
- PCSrcE during MEM or MDU stall: flush suppressed; taken again when stall releases (E held, PCSrcE persists).

## Configuration
- HAZARD_FWD_EN defined: forwarding as above.
- Undefined: ForwardAE/BE tied 2'b00; RAW stall added at load-use priority: (RegWriteE & RdE≠0 & RdE∈{Rs1D,Rs2D}) | (RegWriteM & RdM≠0 & RdM∈{Rs1D,Rs2D}) → StallF, StallD, FlushE. W-stage hazard resolved by register-file write-through.

## Structure
- Package hazard_pkg: state enum (RUN, MDU_BUSY, MEM_WAIT), FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- Sub-module fwd_sel: comparator producing one 2-bit select; instantiated for A and B.

## Test plan
- lw x5 in E, Rs1D=5 → StallF=StallD=FlushE=1 one cycle; next cycle ForwardAE=2'b01.
- RdM=7 RegWriteM, RdW=7 RegWriteW, Rs2E=7 → ForwardBE=2'b10; Rs2E=0, RdM=0 → 2'b00.
- PCSrcE=1, imem_ready=1 → FlushD=FlushE=1, no stalls.
- MduE=1, MDU_CYCLES=4 → StallE=1 for 3 cycles, FlushM=1 each, StallCnt +3.
- MemReqM, dmem_ready low 2 cycles during MDU_BUSY → all stalls + FlushW 2 cycles, then MDU count resumes.
- Reset low mid-MDU_BUSY → outputs 0 asynchronously; after release state RUN, StallCnt 0.
